data_memory_param: RTL and testbench

//  Parametrised MEM stage of the pipelined MIPS core. Replaces the fixed 8-bit data memory stage.
//  - Byte-addressed, word-organised synchronous RAM.
//  - Byte/half/word stores with per-lane write enables; loads sign- or zero-extended.
//  - Registered EX->MEM pipeline state with a stall hold.
//  - Drives the write-back mux: load data when mem_mux_sel=1, ALU result otherwise.

---
 rtl/data_memory_param_if.sv | 30 +++
 rtl/data_memory_param.sv | 197 +++++++++++++++++++
 tb/tb_data_memory_param.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/data_memory_param_if.sv
// Bus bundle between the EX stage (master) and the MEM stage (slave) of the pipelined core.
interface data_memory_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              mem_en_ex;
  logic              mem_rw_ex;
  logic [1:0]        mem_size_ex;
  logic              mem_unsigned_ex;
  logic              mem_mux_sel_ex;
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] B_Bypass;
  logic [REG_W-1:0]  RW_ex;
  logic [DATA_W-1:0] mux_ans_dm;
  logic [REG_W-1:0]  RW_dm;
  logic              misalign_dm;

  modport master (
    output stall, mem_en_ex, mem_rw_ex, mem_size_ex, mem_unsigned_ex, mem_mux_sel_ex,
           ans_ex, B_Bypass, RW_ex,
    input  mux_ans_dm, RW_dm, misalign_dm
  );

  modport slave (
    input  stall, mem_en_ex, mem_rw_ex, mem_size_ex, mem_unsigned_ex, mem_mux_sel_ex,
           ans_ex, B_Bypass, RW_ex,
    output mux_ans_dm, RW_dm, misalign_dm
  );
endinterface

// File: rtl/data_memory_param.sv
// MEM stage: byte-addressed word RAM with byte/half/word access, load extension and stall hold.
// Define DM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses instead of masking offsets.
module data_memory_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_param_if.slave dm
);

  localparam int NLANE  = DATA_W / 8;
  localparam int OFF_W  = $clog2(NLANE);
  localparam int OFF_WI = (OFF_W > 0) ? OFF_W : 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  logic [ADDR_W-1:0] widx;
  logic [OFF_WI-1:0] off_raw;
  logic [OFF_WI-1:0] off_eff;
  size_e             size_eff;
  logic              fault;
  logic              access;
  logic              store_en;
  logic              load_en;
  logic [NLANE-1:0]  lane_we;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       b_pad;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic [REG_W-1:0]  rw_dm_q, rw_dm_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] ans_q, ans_d;
  logic [OFF_WI-1:0] off_q, off_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;

  logic [47:0]       rd_pad;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ext32;
  logic [DATA_W-1:0] load_fmt;

  assign widx = dm.ans_ex[OFF_W+ADDR_W-1:OFF_W];

  generate
    if (OFF_W > 0) begin : g_off
      assign off_raw = dm.ans_ex[OFF_W-1:0];
    end else begin : g_no_off
      assign off_raw = '0;
    end
  endgenerate

  // Half accesses on an 8-bit datapath collapse to a full-word access.
  always_comb begin
    case (dm.mem_size_ex)
      2'b00:   size_eff = SZ_BYTE;
      2'b01:   size_eff = (DATA_W >= 16) ? SZ_HALF : SZ_WORD;
      default: size_eff = SZ_WORD;
    endcase
  end

  always_comb begin
    off_eff = off_raw;
    if (size_eff == SZ_HALF) begin
      off_eff[0] = 1'b0;
    end else if (size_eff == SZ_WORD) begin
      off_eff = '0;
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign fault = dm.mem_en_ex &
                 (((size_eff == SZ_HALF) && off_raw[0]) ||
                  ((size_eff == SZ_WORD) && (off_raw != '0)));

  always_comb begin
    mis_d = mis_q;
    if (!dm.stall) begin
      mis_d = fault;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign dm.misalign_dm = mis_q;
`else
  assign fault          = 1'b0;
  assign dm.misalign_dm = 1'b0;
`endif

  assign access   = dm.mem_en_ex & ~dm.stall;
  assign store_en = access & dm.mem_rw_ex & ~reset & ~fault;
  assign load_en  = access & ~dm.mem_rw_ex;
  assign b_pad    = 32'(dm.B_Bypass);

  // Store data is replicated across lanes so each lane picks its byte without a shifter.
  always_comb begin
    lane_we = '0;
    wdata   = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      case (size_eff)
        SZ_BYTE: begin
          wdata[8*i +: 8] = b_pad[7:0];
          lane_we[i]      = (i == 32'(off_eff));
        end
        SZ_HALF: begin
          wdata[8*i +: 8] = b_pad[8*(i%2) +: 8];
          lane_we[i]      = ((i >> 1) == (32'(off_eff) >> 1));
        end
        default: begin
          wdata[8*i +: 8] = b_pad[8*i +: 8];
          lane_we[i]      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      rdata_q <= mem_q[widx];
    end
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (store_en && lane_we[i]) begin
        mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rw_dm_d = rw_dm_q;
    sel_d   = sel_q;
    ans_d   = ans_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    if (!dm.stall) begin
      rw_dm_d = dm.RW_ex;
      sel_d   = dm.mem_mux_sel_ex;
      ans_d   = dm.ans_ex;
      off_d   = off_eff;
      size_d  = size_eff;
      uns_d   = dm.mem_unsigned_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_dm_q <= '0;
      sel_q   <= 1'b0;
      ans_q   <= '0;
      off_q   <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
    end else begin
      rw_dm_q <= rw_dm_d;
      sel_q   <= sel_d;
      ans_q   <= ans_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  // Padding keeps the lane selects in range for every legal DATA_W.
  always_comb begin
    rd_pad  = 48'(rdata_q);
    ld_byte = rd_pad[8*off_q +: 8];
    ld_half = rd_pad[8*off_q +: 16];
    case (size_q)
      SZ_BYTE: ext32 = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ext32 = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ext32 = rd_pad[31:0];
    endcase
    load_fmt = ext32[DATA_W-1:0];
  end

  assign dm.mux_ans_dm = sel_q ? load_fmt : ans_q;
  assign dm.RW_dm      = rw_dm_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Directed self-checking bench for data_memory_param (DATA_W=32, ADDR_W=10).
module tb_data_memory_param;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  data_memory_param_if #(.DATA_W(32), .REG_W(5)) bus ();

  data_memory_param #(.DATA_W(32), .ADDR_W(10), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .dm    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one EX-stage operation and advance past the capturing edge.
  task automatic issue(input logic en, input logic rw, input logic [1:0] sz, input logic uns,
                       input logic sel, input logic [31:0] ans, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.mem_en_ex       = en;
    bus.mem_rw_ex       = rw;
    bus.mem_size_ex     = sz;
    bus.mem_unsigned_ex = uns;
    bus.mem_mux_sel_ex  = sel;
    bus.ans_ex          = ans;
    bus.B_Bypass        = b;
    bus.RW_ex           = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.stall = 1'b0;
    reset = 1'b1;
    issue(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check_eq("reset_mux", bus.mux_ans_dm, 32'h0);
    check_eq("reset_rw", 32'(bus.RW_dm), 32'd0);
    check_eq("reset_mis", 32'(bus.misalign_dm), 32'd0);
    reset = 1'b0;

    // Store suppressed while reset is high
    issue(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'h11111111, 5'd0);
    reset = 1'b1;
    issue(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h10, 32'hAAAAAAAA, 5'd3);
    check_eq("rst_store_mux", bus.mux_ans_dm, 32'h0);
    check_eq("rst_store_rw", 32'(bus.RW_dm), 32'd0);
    reset = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h10, 32'h0, 5'd2);
    check_eq("rst_keep_ram", bus.mux_ans_dm, 32'h11111111);
    check_eq("rst_keep_rw", 32'(bus.RW_dm), 32'd2);

    // Byte merge into a stored word
    issue(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'hDEADBEEF, 5'd0);
    issue(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h21, 32'h12345655, 5'd0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h20, 32'h0, 5'd5);
    check_eq("word_ld_merge", bus.mux_ans_dm, 32'hDEAD55EF);
    check_eq("word_ld_rw", 32'(bus.RW_dm), 32'd5);

    // Load extension
    issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h23, 32'h0, 5'd6);
    check_eq("byte_s_23", bus.mux_ans_dm, 32'hFFFFFFDE);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h23, 32'h0, 5'd6);
    check_eq("byte_u_23", bus.mux_ans_dm, 32'h000000DE);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h22, 32'h0, 5'd6);
    check_eq("half_s_22", bus.mux_ans_dm, 32'hFFFFDEAD);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h22, 32'h0, 5'd6);
    check_eq("half_u_22", bus.mux_ans_dm, 32'h0000DEAD);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h20, 32'h0, 5'd6);
    check_eq("half_s_20_pos", bus.mux_ans_dm, 32'h000055EF);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h20, 32'h0, 5'd6);
    check_eq("byte_s_20", bus.mux_ans_dm, 32'hFFFFFFEF);

    // Half store into upper lanes
    issue(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h30, 32'h00000000, 5'd0);
    issue(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h32, 32'h1234CAFE, 5'd0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h30, 32'h0, 5'd8);
    check_eq("half_st_32", bus.mux_ans_dm, 32'hCAFE0000);

    // ALU pass-through
    issue(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7);
    check_eq("alu_mux", bus.mux_ans_dm, 32'h00001234);
    check_eq("alu_rw", 32'(bus.RW_dm), 32'd7);

    // Stall hold with a store attempted during the stall
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h20, 32'h0, 5'd9);
    check_eq("pre_stall_ld", bus.mux_ans_dm, 32'hDEAD55EF);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h20, 32'hFFFFFFFF, 5'd4);
      check_eq("stall_mux", bus.mux_ans_dm, 32'hDEAD55EF);
      check_eq("stall_rw", 32'(bus.RW_dm), 32'd9);
    end
    bus.stall = 1'b0;

    // mem_en_ex=0: RAM output holds, pipeline advances
    issue(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h20, 32'h0, 5'd1);
    check_eq("noen_hold", bus.mux_ans_dm, 32'hDEAD55EF);
    check_eq("noen_rw", 32'(bus.RW_dm), 32'd1);

    // High address bits ignored; also proves the stalled store never landed
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h1020, 32'h0, 5'd2);
    check_eq("wrap_ld", bus.mux_ans_dm, 32'hDEAD55EF);

    // Misaligned word and half stores
    issue(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h22, 32'h77777777, 5'd0);
`ifdef DM_MISALIGN_TRAP_EN
    check_eq("mis_word_flag", 32'(bus.misalign_dm), 32'd1);
`else
    check_eq("mis_word_flag", 32'(bus.misalign_dm), 32'd0);
`endif
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h20, 32'h0, 5'd3);
`ifdef DM_MISALIGN_TRAP_EN
    check_eq("mis_word_ram", bus.mux_ans_dm, 32'hDEAD55EF);
`else
    check_eq("mis_word_ram", bus.mux_ans_dm, 32'h77777777);
`endif
    check_eq("mis_clear", 32'(bus.misalign_dm), 32'd0);

    issue(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h31, 32'h0000ABCD, 5'd0);
`ifdef DM_MISALIGN_TRAP_EN
    check_eq("mis_half_flag", 32'(bus.misalign_dm), 32'd1);
`else
    check_eq("mis_half_flag", 32'(bus.misalign_dm), 32'd0);
`endif
    issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h30, 32'h0, 5'd3);
`ifdef DM_MISALIGN_TRAP_EN
    check_eq("mis_half_ram", bus.mux_ans_dm, 32'hCAFE0000);
`else
    check_eq("mis_half_ram", bus.mux_ans_dm, 32'hCAFEABCD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
